mips_pipe_front_regs: RTL

//  Consumer end of the hazard unit: PC register, IF/ID and ID/EX pipeline registers obeying

---
 rtl/mips_pkg.sv | 25 ++
 rtl/sat_counter.sv | 36 +++
 rtl/mips_pipe_front_regs.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS front-end pipeline registers
// Contents:
//   word_t   : default-width datapath word
//   ctrl_t   : decode control bundle {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,ALUControl[2:0]}
//   CTRL_NOP : bubble control word (no register or memory write)
//   PC_INC   : sequential fetch increment in bytes
package mips_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;
  localparam int    PC_INC   = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// Ports:
//   clk   in  : clock, rising edge
//   reset in  : asynchronous active-high reset, clears count
//   inc   in  : count this edge
//   count out : current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mips_pipe_front_regs.sv
// rtl/mips_pipe_front_regs.sv - PC, IF/ID and ID/EX registers driven by the hazard unit
// Ports:
//   clk, reset                   : clock and asynchronous active-high reset
//   stallF, stallD, FlushE       : hazard-unit controls
//   PCSrcD, PCBranchD            : decode-stage branch redirect and target
//   InstrF                       : fetched instruction at PCF
//   PCF                          : fetch PC
//   InstrD, PCPlus4D, validD     : IF/ID contents
//   ctrlD, RD1D, RD2D, SignImmD,
//   RsD, RtD, RdD                : decode-stage values to capture into ID/EX
//   ctrlE, RD1E, RD2E, SignImmE,
//   RsE, RtE, RdE, validE        : ID/EX contents
//   stall_cnt, flush_cnt,
//   redir_cnt                    : saturating cycle counters
//   proto_err                    : sticky flag for illegal hazard-control combinations
module mips_pipe_front_regs
  import mips_pkg::*;
#(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter int           CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             FlushE,
  input  logic             PCSrcD,
  input  logic [W-1:0]     PCBranchD,
  input  logic [W-1:0]     InstrF,
  output logic [W-1:0]     PCF,
  output logic [W-1:0]     InstrD,
  output logic [W-1:0]     PCPlus4D,
  output logic             validD,
  input  logic [7:0]       ctrlD,
  input  logic [W-1:0]     RD1D,
  input  logic [W-1:0]     RD2D,
  input  logic [W-1:0]     SignImmD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  output logic [7:0]       ctrlE,
  output logic [W-1:0]     RD1E,
  output logic [W-1:0]     RD2E,
  output logic [W-1:0]     SignImmE,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic             validE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] redir_cnt,
  output logic             proto_err
);

  logic [W-1:0] pc_plus4_f;

  logic [W-1:0] pcf_q, pcf_d;

  logic [W-1:0] instr_d_q, instr_d_d;
  logic [W-1:0] pc_plus4_d_q, pc_plus4_d_d;
  logic         valid_d_q, valid_d_d;

  ctrl_t        ctrl_e_q, ctrl_e_d;
  logic [W-1:0] rd1_e_q, rd1_e_d;
  logic [W-1:0] rd2_e_q, rd2_e_d;
  logic [W-1:0] imm_e_q, imm_e_d;
  logic [4:0]   rs_e_q, rs_e_d;
  logic [4:0]   rt_e_q, rt_e_d;
  logic [4:0]   rd_e_q, rd_e_d;
  logic         valid_e_q, valid_e_d;

  logic         proto_err_q, proto_err_d;

  assign pc_plus4_f = pcf_q + W'(PC_INC);

  // A stalled fetch also swallows any redirect presented in the same cycle;
  // the hazard unit re-presents the branch once the stall drops.
  always_comb begin
    pcf_d = pcf_q;
    if (!stallF) begin
      pcf_d = PCSrcD ? PCBranchD : pc_plus4_f;
    end
  end

  // stallD wins over the redirect squash so a held decode slot is never lost.
  always_comb begin
    instr_d_d    = instr_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;
    if (stallD) begin
      instr_d_d    = instr_d_q;
    end else if (PCSrcD) begin
      instr_d_d    = '0;
      pc_plus4_d_d = '0;
      valid_d_d    = 1'b0;
    end else begin
      instr_d_d    = InstrF;
      pc_plus4_d_d = pc_plus4_f;
      valid_d_d    = 1'b1;
    end
  end

  // ID/EX never holds: a stalled decode is always paired with FlushE, so the
  // bubble goes downstream while the held instruction waits in IF/ID.
  always_comb begin
    ctrl_e_d  = ctrl_t'(ctrlD);
    rd1_e_d   = RD1D;
    rd2_e_d   = RD2D;
    imm_e_d   = SignImmD;
    rs_e_d    = RsD;
    rt_e_d    = RtD;
    rd_e_d    = RdD;
    valid_e_d = valid_d_q;
    if (FlushE) begin
      ctrl_e_d  = CTRL_NOP;
      rd1_e_d   = '0;
      rd2_e_d   = '0;
      imm_e_d   = '0;
      rs_e_d    = '0;
      rt_e_d    = '0;
      rd_e_d    = '0;
      valid_e_d = 1'b0;
    end
  end

  // Holding decode while fetch advances would drop an instruction; holding
  // decode without flushing execute would issue it twice.
  always_comb begin
    proto_err_d = proto_err_q | (stallD & (~stallF | ~FlushE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf_q <= RESET_PC;
    end else begin
      pcf_q <= pcf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d_q    <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
    end else begin
      instr_d_q    <= instr_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_q  <= CTRL_NOP;
      rd1_e_q   <= '0;
      rd2_e_q   <= '0;
      imm_e_q   <= '0;
      rs_e_q    <= '0;
      rt_e_q    <= '0;
      rd_e_q    <= '0;
      valid_e_q <= 1'b0;
    end else begin
      ctrl_e_q  <= ctrl_e_d;
      rd1_e_q   <= rd1_e_d;
      rd2_e_q   <= rd2_e_d;
      imm_e_q   <= imm_e_d;
      rs_e_q    <= rs_e_d;
      rt_e_q    <= rt_e_d;
      rd_e_q    <= rd_e_d;
      valid_e_q <= valid_e_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallF),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushE),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (PCSrcD & ~stallD),
    .count (redir_cnt)
  );

  assign PCF       = pcf_q;
  assign InstrD    = instr_d_q;
  assign PCPlus4D  = pc_plus4_d_q;
  assign validD    = valid_d_q;
  assign ctrlE     = ctrl_e_q;
  assign RD1E      = rd1_e_q;
  assign RD2E      = rd2_e_q;
  assign SignImmE  = imm_e_q;
  assign RsE       = rs_e_q;
  assign RtE       = rt_e_q;
  assign RdE       = rd_e_q;
  assign validE    = valid_e_q;
  assign proto_err = proto_err_q;

endmodule
